aes_result_scanner: RTL and testbench
=====================================

Name: aes_result_scanner

Overview:
Display-side consumer for the AES cipher/decipher datapath. It captures a 128-bit result on a load strobe and compares it against an expected block to produce a pass LED. It then walks all 16 bytes, most-significant byte first. Each byte is converted to decimal with a sequential double-dabble and shown on three 7-segment digits for a programmable dwell time, replacing the fixed least-significant-byte-only display.

Parameters:
DWELL_CYCLES, 50_000_000, cycles each byte stays on the display (minimum 1).
DW_W, 26, dwell counter width; must satisfy 2^DW_W > DWELL_CYCLES.

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
load  input  1  single-cycle strobe; capture data_in/expected and start a scan
data_in  input  128  block to display (cipher or decipher output)
expected  input  128  reference block for comparison
busy  output  1  high from the cycle after an accepted load until scan completes
done  output  1  high after the last byte's dwell ends; cleared by next accepted load
match  output  1  registered (data_in == expected) at the accepted load
byte_idx  output  4  index of the byte shown; 15 = bits [127:120]
seg_hund  output  7  hundreds digit, active-low, bit0=a .. bit6=g
seg_tens  output  7  tens digit, same encoding
seg_ones  output  7  ones digit, same encoding

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE, busy=0, done=0, match=0, byte_idx=15, all seg outputs 7'h7F (blank), dwell counter=0, capture register=0.
- Digit codes (gfedcba, active-low): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 (hex); blank=7F.
- Leading-zero blanking: hundreds blank when 0; tens blank when hundreds and tens are both 0; ones always shown.
- FSM states: IDLE, CONV, SHOW, DONE.
- Load acceptance: load is accepted only in IDLE or DONE. On acceptance:
  - capture data_in; match <= (data_in==expected); done <= 0; busy <= 1; byte_idx <= 15.
  - load byte [127:120] into the double-dabble shift register with the BCD field cleared.
  - go to CONV.
- load in CONV or SHOW is ignored: no restart and no recapture.
- CONV: exactly 8 cycles. Each cycle adds 3 to every BCD nibble that is >=5, then shifts left by 1. On the 8th cycle, segs update from the BCD result; dwell counter <= 0; go to SHOW.
- SHOW: dwell counter increments each cycle; segs hold. When counter == DWELL_CYCLES-1:
  - if byte_idx==0: go to DONE, busy <= 0, done <= 1.
  - else: byte_idx decrements, the next byte is loaded into the shifter, go to CONV.
- DONE: segs hold the byte-0 value; match holds.
- Latency: with load accepted at edge t, segs show byte 15 from edge t+8. Each byte occupies 8+DWELL_CYCLES cycles. done rises at edge t+16*(8+DWELL_CYCLES).
- During CONV, segs keep the previous byte's value; they are blank only before the first scan after reset.
- rst_n low in any state, including mid-CONV and mid-SHOW, returns everything to reset values on that edge. rst_n has priority over load.
- Counter wrap: byte_idx never wraps below 0; the 0 case exits to DONE.

Decomposition:
- Shared package aes_pkg holds:
  - segment code constants SEG_0..SEG_9 and SEG_BLANK;
  - FSM state encoding (2-bit: IDLE=0, CONV=1, SHOW=2, DONE=3);
  - block width constant AES_BLK_W=128.
- One sub-module: bcd_seg_decode, a purely combinational 4-bit digit to 7-bit segment decoder with a blank input, instantiated three times.
- Double-dabble and FSM stay in the top.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles -> busy=0, done=0, match=0, byte_idx=15, all segs 7F.
- Known vector, DWELL_CYCLES=4: load data_in=expected=69c4e0d86a7b0430d8cdb78070b4c55a.
  - match=1 at t+1.
  - at t+8: byte_idx=15, segs 79/40/12 ("105").
  - next byte c4 (196) shows 79/10/02 at t+20.
  - done=1 at edge t+192.
- Blanking: byte 0x04 -> 7F/7F/19; byte 0x00 -> 7F/7F/40; byte 0xFF -> 24/12/12; byte 0x0A -> 7F/79/40.
- Mismatch and ignored load: expected differs in bit 0 -> match=0. A second load pulse while in SHOW -> byte_idx sequence and timing unchanged.
- Reset mid-scan: assert rst_n=0 during CONV of byte 7 -> next edge all outputs at reset values. A subsequent load restarts at byte_idx=15.
- Restart from DONE: load new block in DONE -> done clears on the next edge, busy=1, scan restarts at byte 15 with new match value.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared constants for the AES result display path: segment codes,
// scanner FSM encoding and block width.
package aes_pkg;

  localparam int AES_BLK_W = 128;

  // Active-low 7-segment codes, bit0=a .. bit6=g
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_SHOW = 2'd2,
    ST_DONE = 2'd3
  } scan_state_t;

endpackage

// File: rtl/bcd_seg_decode.sv
// Combinational BCD digit to active-low 7-segment code with a blank override.
module bcd_seg_decode
  import aes_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (digit)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/aes_result_scanner.sv
// Captures an AES result block, flags a match against the reference and scans
// its 16 bytes MSB-first onto three decimal 7-segment digits.
module aes_result_scanner
  import aes_pkg::*;
#(
  parameter int DWELL_CYCLES = 50_000_000,
  parameter int DW_W         = 26
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [AES_BLK_W-1:0] data_in,
  input  logic [AES_BLK_W-1:0] expected,
  output logic                 busy,
  output logic                 done,
  output logic                 match,
  output logic [3:0]           byte_idx,
  output logic [6:0]           seg_hund,
  output logic [6:0]           seg_tens,
  output logic [6:0]           seg_ones
);

  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL_CYCLES - 1);

  scan_state_t          state_reg;
  logic [AES_BLK_W-1:0] data_reg;
  logic [19:0]          dd_reg;      // {hund, tens, ones, binary byte}
  logic [19:0]          dd_adj;
  logic [19:0]          dd_next;
  logic [2:0]           bit_cnt_reg;
  logic [DW_W-1:0]      dwell_reg;
  logic [3:0]           idx_reg;
  logic [3:0]           idx_dec;
  logic                 busy_reg;
  logic                 done_reg;
  logic                 match_reg;
  logic [6:0]           seg_hund_reg;
  logic [6:0]           seg_tens_reg;
  logic [6:0]           seg_ones_reg;
  logic [6:0]           dec_hund;
  logic [6:0]           dec_tens;
  logic [6:0]           dec_ones;
  logic                 unused_dd_msb;

  // Double-dabble add-3 step on each BCD nibble before the shift
  assign dd_adj[7:0] = dd_reg[7:0];
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_add3
      logic [3:0] nib;
      assign nib = dd_reg[8 + 4*gi +: 4];
      assign dd_adj[8 + 4*gi +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
    end
  endgenerate
  assign dd_next       = {dd_adj[18:0], 1'b0};
  assign unused_dd_msb = dd_adj[19];

  assign idx_dec = idx_reg - 4'd1;

  bcd_seg_decode u_dec_hund (
    .digit (dd_next[19:16]),
    .blank (dd_next[19:16] == 4'd0),
    .seg   (dec_hund)
  );

  bcd_seg_decode u_dec_tens (
    .digit (dd_next[15:12]),
    .blank (dd_next[19:12] == 8'd0),
    .seg   (dec_tens)
  );

  bcd_seg_decode u_dec_ones (
    .digit (dd_next[11:8]),
    .blank (1'b0),
    .seg   (dec_ones)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      data_reg     <= '0;
      dd_reg       <= '0;
      bit_cnt_reg  <= '0;
      dwell_reg    <= '0;
      idx_reg      <= 4'd15;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      match_reg    <= 1'b0;
      seg_hund_reg <= SEG_BLANK;
      seg_tens_reg <= SEG_BLANK;
      seg_ones_reg <= SEG_BLANK;
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (load) begin
            data_reg    <= data_in;
            match_reg   <= (data_in == expected);
            done_reg    <= 1'b0;
            busy_reg    <= 1'b1;
            idx_reg     <= 4'd15;
            dd_reg      <= {12'd0, data_in[AES_BLK_W-1 -: 8]};
            bit_cnt_reg <= '0;
            state_reg   <= ST_CONV;
          end
        end
        ST_CONV: begin
          dd_reg      <= dd_next;
          bit_cnt_reg <= bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == 3'd7) begin
            seg_hund_reg <= dec_hund;
            seg_tens_reg <= dec_tens;
            seg_ones_reg <= dec_ones;
            dwell_reg    <= '0;
            state_reg    <= ST_SHOW;
          end
        end
        ST_SHOW: begin
          dwell_reg <= dwell_reg + 1'b1;
          if (dwell_reg == DWELL_LAST) begin
            if (idx_reg == 4'd0) begin
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
              state_reg <= ST_DONE;
            end else begin
              idx_reg     <= idx_dec;
              dd_reg      <= {12'd0, data_reg[{idx_dec, 3'b000} +: 8]};
              bit_cnt_reg <= '0;
              state_reg   <= ST_CONV;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign busy     = busy_reg;
  assign done     = done_reg;
  assign match    = match_reg;
  assign byte_idx = idx_reg;
  assign seg_hund = seg_hund_reg;
  assign seg_tens = seg_tens_reg;
  assign seg_ones = seg_ones_reg;

endmodule

// File: tb/tb_aes_result_scanner.sv
// Directed bench for aes_result_scanner with a short dwell of 4 cycles.
module tb_aes_result_scanner;

  localparam logic [127:0] V1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] V2 = 128'hff0a0004_11223344_55667788_99aabbcc;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         load = 1'b0;
  logic [127:0] data_in = '0;
  logic [127:0] expected = '0;
  logic         busy, done, match;
  logic [3:0]   byte_idx;
  logic [6:0]   seg_hund, seg_tens, seg_ones;

  int checks = 0;
  int failures = 0;
  int off = 0;

  always #5 clk = ~clk;

  aes_result_scanner #(.DWELL_CYCLES(4), .DW_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .data_in  (data_in),
    .expected (expected),
    .busy     (busy),
    .done     (done),
    .match    (match),
    .byte_idx (byte_idx),
    .seg_hund (seg_hund),
    .seg_tens (seg_tens),
    .seg_ones (seg_ones)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Advance to offset k edges after the last accepted load
  task automatic go(input int k);
    step(k - off);
    off = k;
  endtask

  task automatic check_segs(input string tag, input logic [6:0] h, input logic [6:0] t, input logic [6:0] o);
    check_eq({tag, "_hund"}, seg_hund, h);
    check_eq({tag, "_tens"}, seg_tens, t);
    check_eq({tag, "_ones"}, seg_ones, o);
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_match"}, match, 0);
    check_eq({tag, "_idx"}, byte_idx, 15);
    check_segs(tag, 7'h7F, 7'h7F, 7'h7F);
  endtask

  task automatic do_load(input logic [127:0] d, input logic [127:0] e);
    data_in  = d;
    expected = e;
    load     = 1'b1;
    step(1);
    load = 1'b0;
    off  = 0;
  endtask

  initial begin
    step(3);
    check_reset_state("rst");
    rst_n = 1'b1;
    step(2);
    check_reset_state("idle");

    // Full scan of the known vector with a matching reference
    do_load(V1, V1);
    check_eq("v1_match", match, 1);
    check_eq("v1_busy", busy, 1);
    check_eq("v1_done", done, 0);
    check_eq("v1_idx", byte_idx, 15);
    go(4);
    check_segs("v1_conv_blank", 7'h7F, 7'h7F, 7'h7F);
    go(8);
    check_segs("b15_105", 7'h79, 7'h40, 7'h12);
    go(19);
    check_eq("b14_idx", byte_idx, 14);
    check_segs("b14_hold", 7'h79, 7'h40, 7'h12);
    go(20);
    check_segs("b14_196", 7'h79, 7'h10, 7'h02);
    // Load during SHOW must be ignored
    go(21);
    data_in  = V2;
    expected = '0;
    load     = 1'b1;
    go(22);
    load = 1'b0;
    check_eq("ign_match", match, 1);
    check_eq("ign_idx", byte_idx, 14);
    go(32);
    check_segs("b13_224", 7'h24, 7'h24, 7'h19);
    go(80);
    check_eq("b9_idx", byte_idx, 9);
    check_segs("b9_004", 7'h7F, 7'h7F, 7'h19);
    go(191);
    check_eq("pre_done", done, 0);
    check_eq("pre_busy", busy, 1);
    go(192);
    check_eq("done", done, 1);
    check_eq("done_busy", busy, 0);
    check_eq("done_idx", byte_idx, 0);
    check_segs("b0_090", 7'h7F, 7'h10, 7'h40);
    go(196);
    check_eq("done_hold", done, 1);
    check_eq("done_match", match, 1);

    // Restart from DONE with a one-bit mismatch; walks the blanking cases
    do_load(V2, V2 ^ 128'h1);
    check_eq("v2_done_clr", done, 0);
    check_eq("v2_busy", busy, 1);
    check_eq("v2_match", match, 0);
    check_eq("v2_idx", byte_idx, 15);
    check_segs("v2_conv_hold", 7'h7F, 7'h10, 7'h40);
    go(8);
    check_segs("b15_255", 7'h24, 7'h12, 7'h12);
    go(20);
    check_segs("b14_010", 7'h7F, 7'h79, 7'h40);
    go(32);
    check_segs("b13_000", 7'h7F, 7'h7F, 7'h40);
    go(44);
    check_segs("b12_004", 7'h7F, 7'h7F, 7'h19);

    // Reset in the middle of byte 7 conversion
    go(99);
    check_eq("b7_idx", byte_idx, 7);
    rst_n = 1'b0;
    go(100);
    check_reset_state("midrst");
    rst_n = 1'b1;
    step(2);

    // Fresh scan after reset restarts at byte 15
    do_load(V1, V1);
    check_eq("rs_idx", byte_idx, 15);
    check_eq("rs_match", match, 1);
    go(4);
    check_segs("rs_conv_blank", 7'h7F, 7'h7F, 7'h7F);
    go(8);
    check_segs("rs_b15", 7'h79, 7'h40, 7'h12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
